// File: rtl/seq_div_pkg.sv
// seq_div_pkg
//   Shared definitions for the sequential divider:
//     - SEQ_DIV_WIDTH  : default operand/result width
//     - SEQ_DIV_CNT_W  : iteration-counter width for the default width
//     - div_state_t    : controller state encoding (IDLE, CALC, DONE)
//     - cnt_width()    : counter width for any operand width
package seq_div_pkg;

  localparam int SEQ_DIV_WIDTH = 16;

  // The counter runs 0 .. WIDTH-1, so clog2(WIDTH) bits are enough.
  localparam int SEQ_DIV_CNT_W = $clog2(SEQ_DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// div_addsub
//   Trial subtractor for the restoring divider: diff = a - b, computed one
//   bit wider than the operands so that the extra bit is the borrow-out.
//   borrow = 1 means a < b (the caller keeps the old partial remainder).
//
//   Parameters : W      operand width (divider WIDTH+1)
//   Inputs     : a, b   [W-1:0] minuend, subtrahend
//   Outputs    : diff   [W-1:0] a - b (mod 2^W)
//                borrow 1 when a < b
module div_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider16.sv
// seq_divider16
//   Multi-cycle restoring divider, one quotient bit per clock, MSB first.
//   Operation: accept (in_valid & in_ready) -> WIDTH CALC cycles -> DONE,
//   result held until out_ready; divisor 0 skips CALC and goes straight to
//   DONE with quotient all-ones, remainder = dividend, div_by_zero = 1.
//
//   Optional build macro SEQ_DIV_SIGNED_EN: two's-complement operands, the
//   core divides magnitudes and a sign fix-up is applied while loading the
//   result registers (quotient truncates toward zero, remainder takes the
//   dividend's sign). Without the macro no sign logic exists.
//
//   Handshake rules (both sides): a transfer happens on a rising edge where
//   valid and ready are both 1. in_ready is high only in IDLE, out_valid is
//   high only in DONE; in_valid is ignored outside IDLE and out_ready is
//   ignored outside DONE. Result outputs stay stable while out_valid is held.
//
//   Ports:
//     clk         in   clock, rising edge
//     rst_n       in   synchronous active-low reset
//     in_valid    in   operands valid
//     in_ready    out  divider idle, can accept
//     dividend    in   [WIDTH-1:0] numerator
//     divisor     in   [WIDTH-1:0] denominator
//     out_valid   out  result valid
//     out_ready   in   consumer accepts result
//     quotient    out  [WIDTH-1:0]
//     remainder   out  [WIDTH-1:0]
//     div_by_zero out  divisor was zero for this result
//
//   Internal debug: `state` carries the controller state (div_state_t).
module seq_divider16
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t state, state_nxt;

  logic [WIDTH-1:0] rem_r;   // partial remainder
  logic [WIDTH-1:0] quo_r;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_r;   // registered divisor (magnitude)
  logic [CW-1:0]    cnt_r;   // iteration index within CALC

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             last_iter;
  logic             div0;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             diff_msb_unused;

  // ---------------------------------------------------------------------
  // Trial subtraction: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor. A borrow means the divisor
  // did not fit, so the shifted value is kept (restored) and a 0 enters
  // the quotient.
  // ---------------------------------------------------------------------
  assign trial = {rem_r, quo_r[WIDTH-1]};

  div_addsub #(.W(WIDTH + 1)) u_addsub (
    .a      (trial),
    .b      ({1'b0, dvs_r}),
    .diff   (diff),
    .borrow (borrow)
  );

  // When no borrow occurs the difference is below the divisor, so its top
  // bit is always zero and only WIDTH bits are kept.
  assign diff_msb_unused = diff[WIDTH];

  assign rem_nxt   = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt   = {quo_r[WIDTH-2:0], ~borrow};
  assign last_iter = (cnt_r == CW'(WIDTH - 1));
  assign div0      = (divisor == '0);

  // ---------------------------------------------------------------------
  // Operand conditioning and result fix-up
  // ---------------------------------------------------------------------
`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q_r;   // quotient must be negated
  logic neg_r_r;   // remainder must be negated (follows dividend sign)

  assign a_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign b_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  // most-negative / -1: magnitude quotient is 2^(WIDTH-1) with no negation,
  // which is exactly the wrapped most-negative result.
  assign q_fix = neg_q_r ? (~quo_nxt + 1'b1) : quo_nxt;
  assign r_fix = neg_r_r ? (~rem_nxt + 1'b1) : rem_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (state == ST_IDLE && in_valid) begin
      neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_r <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quo_nxt;
  assign r_fix = rem_nxt;
`endif

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = div0 ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath. Result registers are written only when entering DONE, so
  // they hold still for the whole DONE stay.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      cnt_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rem_r <= '0;
            quo_r <= a_mag;
            dvs_r <= b_mag;
            cnt_r <= '0;
            if (div0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          rem_r <= rem_nxt;
          quo_r <= quo_nxt;
          cnt_r <= cnt_r + 1'b1;
          if (last_iter) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16
//   Random and directed operations against an arithmetic reference model;
//   expected results are queued at accept and checked by an independent
//   monitor whenever the divider presents a result.
//   Build option SEQ_DIV_SIGNED_EN switches the model to signed arithmetic.
module tb_seq_divider16;

  localparam int W = 16;

  // ------------------------------------------------------------ clock/reset
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ------------------------------------------------------------ scoreboard
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [7:0]   lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc_cyc = 0;
  logic holding = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
`ifdef SEQ_DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    e.dz  = 1'b0;
    e.lat = 8'd17;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 8'd1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // ------------------------------------------------------------ out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // ------------------------------------------------------------ monitor
  initial begin
    exp_t         cur;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    logic         hdz;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 1'b0;
      end else if (out_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            check("stray_out_valid", 32'(out_valid), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            check("quotient", 32'(quotient), 32'(cur.q));
            check("remainder", 32'(remainder), 32'(cur.r));
            check("div_by_zero", 32'(div_by_zero), 32'(cur.dz));
            check("latency", 32'(cyc - acc_cyc + 1), 32'(cur.lat));
            hq = quotient;
            hr = remainder;
            hdz = div_by_zero;
            holding = 1'b1;
          end
        end else begin
          check("hold_stable", {15'd0, hdz, hq, hr} ^ 32'd0, {15'd0, div_by_zero, quotient, remainder});
          check("in_ready_in_done", 32'(in_ready), 32'd0);
        end
        if (out_ready) holding = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b));
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble operands after accept; the result must not change.
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || holding || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || holding || !in_ready) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    do_op(16'd100, 16'd7);
    wait_drain();
    do_op(16'd8, 16'd4);
    do_op(16'd4, 16'd8);
    do_op(16'hFFFF, 16'd1);
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'd1234, 16'd0);
    do_op(16'd0, 16'd5);
    wait_drain();
`ifdef SEQ_DIV_SIGNED_EN
    do_op(-16'sd100, 16'sd7);
    do_op(16'sd100, -16'sd7);
    do_op(16'h8000, 16'hFFFF);
    do_op(16'h8000, 16'd0);
    wait_drain();
`endif

    // Held result: consumer stalls 5 cycles in DONE
    rdy_force = 1'b0;
    do_op(16'd1000, 16'd3);
    n = 0;
    while (!holding && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", 32'(holding), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_force = 1'b1;
    wait_drain();
    do_op(16'd50, 16'd5);
    wait_drain();

    // Reset in the middle of CALC
    do_op(16'hABCD, 16'h0012);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (25) @(negedge clk);
    do_op(16'd9, 16'd2);
    wait_drain();

    // Random traffic with random consumer back-pressure
    rdy_rand = 1'b1;
    repeat (150) begin
      a = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
      else b = W'($urandom);
      if ($urandom_range(0, 9) == 0) a = W'($urandom_range(0, 3));
      do_op(a, b);
    end
    wait_drain();
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ------------------------------------------------------------ watchdog
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider16.md
SEQ_DIVIDER16 -- requirements
Module: seq_divider16

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  divider can accept an operation.
REQ-006 dividend  input  WIDTH  numerator.
REQ-007 divisor  input  WIDTH  denominator.
REQ-008 out_valid  output  1  quotient/remainder/div_by_zero valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  WIDTH  dividend / divisor.
REQ-011 remainder  output  WIDTH  dividend mod divisor.
REQ-012 div_by_zero  output  1  divisor was zero for this result.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept SHALL occur on an edge with in_valid=1 and in_ready=1; operands are registered then; later input changes have no effect.
REQ-016 On accept with divisor!=0: IDLE->CALC; restoring algorithm, one quotient bit per cycle, MSB first, using a WIDTH+1-bit trial subtraction.
REQ-017 CALC SHALL last exactly WIDTH cycles, then go to DONE; out_valid first asserts WIDTH+1 cycles after the accept edge (17 for WIDTH=16).
REQ-018 On accept with divisor=0: IDLE->DONE directly (out_valid 1 cycle after accept), quotient all-ones, remainder=dividend, div_by_zero=1.
REQ-019 div_by_zero SHALL be 0 for every nonzero-divisor result.
REQ-020 Results SHALL be unsigned and exact: dividend = quotient*divisor + remainder, remainder < divisor.
REQ-021 In DONE, outputs SHALL hold stable until out_valid and out_ready are both 1 on an edge; then DONE->IDLE.
REQ-022 No back-to-back overlap: the next accept occurs no earlier than the edge after the result handshake (in_ready rises the cycle after DONE exits).
REQ-023 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.

Reset
REQ-024 rst_n=0 on an edge SHALL force IDLE and clear quotient, remainder, div_by_zero and out_valid to 0; in_ready is 1 the first cycle after reset releases.
REQ-025 Reset during CALC or DONE SHALL abandon the operation; no result is ever presented for it.

Configuration
REQ-026 Macro SEQ_DIV_SIGNED_EN: when defined, operands and results are two's complement, quotient truncates toward zero, remainder takes the dividend's sign; the core still divides magnitudes, with a sign fix-up applied on entry to DONE (latency unchanged).
REQ-027 With SEQ_DIV_SIGNED_EN defined: divisor=0 gives quotient all-ones, remainder=dividend, div_by_zero=1; most-negative / -1 gives quotient=most-negative, remainder=0.
REQ-028 Without SEQ_DIV_SIGNED_EN: unsigned only; no sign logic is synthesised.

Structure
REQ-029 Package seq_div_pkg SHALL hold the FSM state encoding, default WIDTH and the iteration-counter width constant.
REQ-030 The trial subtraction SHALL be a sub-module div_addsub (WIDTH+1-bit subtract with borrow-out); the borrow-out selects restore or keep.

Verification
REQ-031 100/7 -> out_valid on cycle 17 after accept; quotient=14, remainder=2, div_by_zero=0.
REQ-032 8/4 -> 2 r 0; 4/8 -> 0 r 4; 0xFFFF/1 -> 0xFFFF r 0; 0xFFFF/0xFFFF -> 1 r 0.
REQ-033 1234/0 -> out_valid 1 cycle after accept; quotient=0xFFFF, remainder=1234, div_by_zero=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; the handshake then returns to IDLE, and the next op (50/5) gives 10 r 0.
REQ-035 rst_n=0 on cycle 8 of CALC -> all outputs 0, in_ready=1 after release, no stray out_valid; a new op (9/2) gives 4 r 1.
REQ-036 With SEQ_DIV_SIGNED_EN: -100/7 -> -14 r -2; 100/-7 -> -14 r 2; 0x8000/0xFFFF -> 0x8000 r 0.
